pmu_switch_sequencer: RTL and testbench

//  Sequences CPU-requested clock-speed changes into the power manager on the PMU reference clock.

---
 rtl/pmu_switch_sequencer_pkg.sv | 27 ++
 rtl/pmu_switch_sequencer_quiet_cnt.sv | 45 ++++
 rtl/pmu_switch_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pmu_switch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_switch_sequencer_pkg.sv
// Shared definitions for the PMU clock-speed switch sequencer: state encoding,
// default code width and counter sizing helpers.
package pmu_switch_sequencer_pkg;

    localparam int unsigned PMU_CODE_W_DEF = 8;

    typedef enum logic [2:0] {
        PMU_ST_IDLE   = 3'd0,
        PMU_ST_DRAIN  = 3'd1,
        PMU_ST_SWITCH = 3'd2,
        PMU_ST_SETTLE = 3'd3,
        PMU_ST_DONE   = 3'd4
    } pmu_state_e;

    function automatic int unsigned pmu_cnt_w(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int unsigned pmu_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pmu_switch_sequencer_quiet_cnt.sv
// Saturating count of consecutive UART-idle cycles. quiet looks ahead one cycle:
// it is high in the cycle that completes QUIET_CYCLES idle cycles in a row.
module pmu_switch_sequencer_quiet_cnt
    import pmu_switch_sequencer_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic clr,
    output logic quiet
);

    localparam int unsigned W = pmu_cnt_w(QUIET_CYCLES);
    localparam logic [W-1:0] SAT_V  = W'(QUIET_CYCLES);
    localparam logic [W-1:0] LAST_V = W'(QUIET_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count idle cycles, restart on any busy cycle or when the owner clears.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !idle) begin
            cnt_d = '0;
        end else if (cnt_q != SAT_V) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign quiet = idle & (cnt_q >= LAST_V);

endmodule

// File: rtl/pmu_switch_sequencer.sv
// Sequences CPU speed-change requests into the power manager once the UART is quiet.
// Optional drain timeout is enabled by defining PMU_SEQ_TIMEOUT_EN.
module pmu_switch_sequencer
    import pmu_switch_sequencer_pkg::*;
#(
    parameter int unsigned CODE_W        = PMU_CODE_W_DEF,
    parameter int unsigned MAX_CODE      = 3,
    parameter int unsigned QUIET_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned TIMEOUT_CYC   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [CODE_W-1:0] req_code,
    input  logic              uart_tx_busy,
    input  logic              uart_rx_busy,
    output logic              change,
    output logic [CODE_W-1:0] change_vec,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CODE_W-1:0] cur_code,
    output logic              timed_out
);

    localparam int unsigned CNT_W = pmu_cnt_w(pmu_max3(QUIET_CYCLES, SETTLE_CYCLES, TIMEOUT_CYC));
    localparam logic [CNT_W-1:0]  SETTLE_LAST_V = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CODE_W-1:0] MAX_CODE_V    = CODE_W'(MAX_CODE);

    pmu_state_e        state_q, state_d;
    logic [CODE_W-1:0] tgt_q, tgt_d;
    logic [CODE_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              change_q, change_d;
    logic [CODE_W-1:0] change_vec_q, change_vec_d;
    logic [CODE_W-1:0] cur_code_q, cur_code_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;

    logic idle_s;
    logic quiet_s;
    logic quiet_clr_s;
    logic req_legal_s;

`ifdef PMU_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST_V = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             timed_out_q, timed_out_d;
`endif

    assign idle_s      = ~uart_tx_busy & ~uart_rx_busy;
    assign quiet_clr_s = (state_q != PMU_ST_DRAIN);
    assign req_legal_s = req & (req_code <= MAX_CODE_V);

    pmu_switch_sequencer_quiet_cnt #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_quiet_cnt (
        .clk   (clk),
        .reset (reset),
        .idle  (idle_s),
        .clr   (quiet_clr_s),
        .quiet (quiet_s)
    );

    // Next-state, pending queue and registered-output logic.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        change_d     = 1'b0;
        change_vec_d = change_vec_q;
        cur_code_d   = cur_code_q;
        done_d       = 1'b0;
        err_d        = req & ~req_legal_s;
        settle_cnt_d = '0;
`ifdef PMU_SEQ_TIMEOUT_EN
        timed_out_d  = timed_out_q;
        to_cnt_d     = (state_q == PMU_ST_DRAIN) ? (to_cnt_q + 1'b1) : '0;
`endif

        case (state_q)
            PMU_ST_IDLE: begin
                // A request left behind by DONE takes priority over a new one.
                if (pend_vld_q) begin
                    tgt_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = PMU_ST_DRAIN;
                end else if (req_legal_s) begin
                    tgt_d   = req_code;
                    state_d = PMU_ST_DRAIN;
                end else begin
                    state_d = PMU_ST_IDLE;
                end
            end
            PMU_ST_DRAIN: begin
                if (quiet_s) begin
                    state_d      = PMU_ST_SWITCH;
                    change_d     = 1'b1;
                    change_vec_d = tgt_q;
                    cur_code_d   = tgt_q;
`ifdef PMU_SEQ_TIMEOUT_EN
                end else if (to_cnt_q == TIMEOUT_LAST_V) begin
                    state_d      = PMU_ST_SWITCH;
                    change_d     = 1'b1;
                    change_vec_d = tgt_q;
                    cur_code_d   = tgt_q;
                    timed_out_d  = 1'b1;
`endif
                end else begin
                    state_d = PMU_ST_DRAIN;
                end
            end
            PMU_ST_SWITCH: begin
                state_d = PMU_ST_SETTLE;
            end
            PMU_ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST_V) begin
                    state_d = PMU_ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                    state_d      = PMU_ST_SETTLE;
                end
            end
            PMU_ST_DONE: begin
                if (pend_vld_q) begin
                    tgt_d      = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = PMU_ST_DRAIN;
                end else begin
                    state_d = PMU_ST_IDLE;
                end
            end
            default: begin
                state_d = PMU_ST_IDLE;
            end
        endcase

        // Requests arriving while a sequence is in flight coalesce, last one wins.
        if (req_legal_s && ((state_q != PMU_ST_IDLE) || pend_vld_q)) begin
            pend_d     = req_code;
            pend_vld_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end

        busy_d = (state_d != PMU_ST_IDLE) | pend_vld_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PMU_ST_IDLE;
            tgt_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            change_q     <= 1'b0;
            change_vec_q <= '0;
            cur_code_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            change_q     <= change_d;
            change_vec_q <= change_vec_d;
            cur_code_q   <= cur_code_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

`ifdef PMU_SEQ_TIMEOUT_EN
    // Drain timeout counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

    assign change     = change_q;
    assign change_vec = change_vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cur_code   = cur_code_q;

endmodule

// File: tb/tb_pmu_switch_sequencer.sv
// Directed self-checking bench for pmu_switch_sequencer (QUIET=16, SETTLE=64, TIMEOUT=256).
module tb_pmu_switch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [7:0] req_code;
    logic       uart_tx_busy;
    logic       uart_rx_busy;
    logic       change;
    logic [7:0] change_vec;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cur_code;
    logic       timed_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ch_q[$];
    int chv_q[$];
    int dn_q[$];
    int er_q[$];

    typedef struct {
        logic [7:0] code;
        bit         use_rx;
        int         busy_len;
        int         glitch;
        int         exp_change;
        int         exp_done;
        logic [7:0] exp_cur;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    pmu_switch_sequencer #(
        .CODE_W        (8),
        .MAX_CODE      (3),
        .QUIET_CYCLES  (16),
        .SETTLE_CYCLES (64),
        .TIMEOUT_CYC   (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_code     (req_code),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_busy (uart_rx_busy),
        .change       (change),
        .change_vec   (change_vec),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cur_code     (cur_code),
        .timed_out    (timed_out)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (change) begin
            ch_q.push_back(cyc);
            chv_q.push_back(int'(change_vec));
        end
        if (done) dn_q.push_back(cyc);
        if (err)  er_q.push_back(cyc);
    endtask

    task automatic start_seq();
        ch_q.delete();
        chv_q.delete();
        dn_q.delete();
        er_q.delete();
        cyc = 0;
    endtask

    task automatic drive_bus(input vec_t v, input int c);
        bit bz;
        bz = (c < v.busy_len) || (c == v.glitch);
        uart_tx_busy = !v.use_rx && bz;
        uart_rx_busy = v.use_rx && bz;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req_code = 8'd0;
        uart_tx_busy = 1'b0; uart_rx_busy = 1'b0;
        repeat (3) tick();
        chk("rst_change", change, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_cur_code", cur_code, 0);
        chk("rst_change_vec", change_vec, 0);
        reset = 1'b0;
        tick();

        // code, use_rx, busy_len, glitch, change cycle, done cycle, cur_code
        tbl[0] = '{8'd2, 1'b0,   0,  -1,  17,  82, 8'd2};
        tbl[1] = '{8'd1, 1'b0, 100, 108, 125, 190, 8'd1};
        tbl[2] = '{8'd3, 1'b1,   5,  -1,  21,  86, 8'd3};
        tbl[3] = '{8'd3, 1'b0,   0,  -1,  17,  82, 8'd3};
        tbl[4] = '{8'd0, 1'b1,   0,  10,  27,  92, 8'd0};

        for (int i = 0; i < 5; i++) begin
            start_seq();
            req = 1'b1; req_code = tbl[i].code;
            drive_bus(tbl[i], 0);
            for (int c = 1; c <= tbl[i].exp_done + 2; c++) begin
                tick();
                req = 1'b0;
                drive_bus(tbl[i], cyc);
                if (cyc == 1) chk($sformatf("row%0d_busy_after_req", i), busy, 1);
            end
            chk($sformatf("row%0d_n_change", i), ch_q.size(), 1);
            chk($sformatf("row%0d_change_cyc", i), ch_q[0], tbl[i].exp_change);
            chk($sformatf("row%0d_change_vec", i), chv_q[0], int'(tbl[i].exp_cur));
            chk($sformatf("row%0d_n_done", i), dn_q.size(), 1);
            chk($sformatf("row%0d_done_cyc", i), dn_q[0], tbl[i].exp_done);
            chk($sformatf("row%0d_n_err", i), er_q.size(), 0);
            chk($sformatf("row%0d_cur_code", i), cur_code, int'(tbl[i].exp_cur));
            chk($sformatf("row%0d_busy_end", i), busy, 0);
        end

        // Illegal code while idle
        start_seq();
        req = 1'b1; req_code = 8'd5;
        tick();
        req = 1'b0;
        chk("idle_err_pulse", err, 1);
        chk("idle_err_busy", busy, 0);
        tick();
        chk("idle_err_clear", err, 0);
        repeat (30) tick();
        chk("idle_err_no_change", ch_q.size(), 0);
        chk("idle_err_cur", cur_code, 0);

        // Coalesced pending, illegal code in SETTLE, request on the DONE cycle
        start_seq();
        req = 1'b1; req_code = 8'd2;
        for (int c = 1; c <= 252; c++) begin
            tick();
            req = 1'b0;
            if (cyc == 20)  begin req = 1'b1; req_code = 8'd1; end
            if (cyc == 25)  begin req = 1'b1; req_code = 8'd3; end
            if (cyc == 40)  begin req = 1'b1; req_code = 8'd4; end
            if (cyc == 164) begin req = 1'b1; req_code = 8'd0; end
            if (cyc == 83)  chk("pend_busy_drain2", busy, 1);
            if (cyc == 165) chk("pend_busy_idle_pending", busy, 1);
        end
        chk("pend_n_change", ch_q.size(), 3);
        chk("pend_change0", ch_q[0], 17);
        chk("pend_change1", ch_q[1], 99);
        chk("pend_change2", ch_q[2], 182);
        chk("pend_vec0", chv_q[0], 2);
        chk("pend_vec1", chv_q[1], 3);
        chk("pend_vec2", chv_q[2], 0);
        chk("pend_n_done", dn_q.size(), 3);
        chk("pend_done1", dn_q[1], 164);
        chk("pend_done2", dn_q[2], 247);
        chk("pend_n_err", er_q.size(), 1);
        chk("pend_err_cyc", er_q[0], 41);
        chk("pend_busy_end", busy, 0);

        // Reset during SETTLE with a pending request held
        start_seq();
        req = 1'b1; req_code = 8'd3;
        for (int c = 1; c <= 150; c++) begin
            tick();
            req = 1'b0;
            if (cyc == 20) begin req = 1'b1; req_code = 8'd1; end
            if (cyc == 30) reset = 1'b1;
            if (cyc == 31) begin
                chk("rst_settle_busy", busy, 0);
                chk("rst_settle_cur", cur_code, 0);
                chk("rst_settle_vec", change_vec, 0);
                chk("rst_settle_done", done, 0);
                reset = 1'b0;
            end
        end
        chk("rst_settle_n_change", ch_q.size(), 1);
        chk("rst_settle_n_done", dn_q.size(), 0);

        // Reset during DRAIN
        start_seq();
        req = 1'b1; req_code = 8'd2;
        for (int c = 1; c <= 120; c++) begin
            tick();
            req = 1'b0;
            if (cyc == 5) reset = 1'b1;
            if (cyc == 6) begin
                chk("rst_drain_busy", busy, 0);
                chk("rst_drain_change", change, 0);
                reset = 1'b0;
            end
        end
        chk("rst_drain_n_change", ch_q.size(), 0);
        chk("rst_drain_cur", cur_code, 0);

        // Receiver stuck busy
        start_seq();
        uart_rx_busy = 1'b1;
        req = 1'b1; req_code = 8'd1;
`ifdef PMU_SEQ_TIMEOUT_EN
        for (int c = 1; c <= 330; c++) begin
            tick();
            req = 1'b0;
            if (cyc == 256) chk("to_not_yet", timed_out, 0);
        end
        chk("to_n_change", ch_q.size(), 1);
        chk("to_change_cyc", ch_q[0], 257);
        chk("to_done_cyc", dn_q[0], 322);
        chk("to_flag", timed_out, 1);
        uart_rx_busy = 1'b0;
        repeat (5) tick();
        chk("to_sticky", timed_out, 1);
`else
        for (int c = 1; c <= 10000; c++) begin
            tick();
            req = 1'b0;
        end
        chk("stuck_n_change", ch_q.size(), 0);
        chk("stuck_busy", busy, 1);
        chk("stuck_timed_out", timed_out, 0);
        uart_rx_busy = 1'b0;
        for (int c = 1; c <= 90; c++) tick();
        chk("stuck_release_n_change", ch_q.size(), 1);
        chk("stuck_release_change", ch_q[0], 10016);
        chk("stuck_release_done", dn_q[0], 10081);
        chk("stuck_release_cur", cur_code, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
